// File: rtl/dma_axi_write_master_if.sv
// AXI4 write-channel bundle (AW, W, B) between the DMA write engine and memory.
// Latency: none, wires only.
// Backpressure: carried by awready, wready and bvalid/bready inside the bundle.
// Ports: master drives AW/W and bready; slave drives awready, wready, bresp, bvalid.
interface dma_axi_write_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BYTES = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_WIDTH-1:0] wdata;
  logic [BYTES-1:0]      wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/dma_axi_write_master.sv
// DMA write engine: drains the DMA FIFO into memory as AXI4 INCR bursts split at MAX_BURST and 4 KB.
// Latency: awvalid 1 cycle after start; first beat 2 cycles after the AW handshake; done 1 cycle after the last B.
// Backpressure: one burst in flight; FIFO reads stall while wvalid && !wready or the FIFO is empty.
// Ports: clk/rst_n; start, dst_addr, xfer_len in; busy, done, error out;
//        fifo_ren out, fifo_empty/fifo_data in (data registered, valid the cycle after fifo_ren);
//        axi: AW/W/B channels of the memory write port.
module dma_axi_write_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int MAX_BURST  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  xfer_len,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  fifo_ren,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  dma_axi_write_master_if.master axi
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);
  // Wide enough for both the remaining length and the beats left before 4 KB.
  localparam int CW    = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << SIZE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AW,
    S_W,
    S_B,
    S_DONE
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]  rem;
  logic [8:0]            fetch_left;
  logic [8:0]            send_left;
  logic                  wvalid_q;
  logic                  error_q;

  logic [12:0]           to_4k_bytes;
  logic [CW-1:0]         to_4k;
  logic [CW-1:0]         beats_w;
  logic [8:0]            beats;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  wlast_i;
  logic                  b_hs;
  logic                  b_err;
  logic                  last_burst;
  logic                  ren_i;

  // Burst length: min(remaining, MAX_BURST, beats left in this 4 KB page).
  // Only addr/rem feed it, and they change only at start and at the B handshake.
  always_comb begin
    to_4k_bytes = 13'h1000 - {1'b0, addr[11:0]};
    to_4k       = CW'(to_4k_bytes >> SIZE);
    beats_w     = CW'(rem);
    if (CW'(MAX_BURST) < beats_w) beats_w = CW'(MAX_BURST);
    if (to_4k < beats_w)          beats_w = to_4k;
  end

  assign beats      = 9'(beats_w);
  assign aw_hs      = (state == S_AW) && axi.awready;
  assign w_hs       = wvalid_q && axi.wready;
  assign wlast_i    = wvalid_q && (send_left == 9'd1);
  assign b_hs       = (state == S_B) && axi.bvalid;
  assign b_err      = axi.bresp != 2'b00;
  assign last_burst = CW'(rem) == CW'(beats);
  // Never read while a beat is stalled, so the registered fifo_data stays put.
  assign ren_i      = (state == S_W) && !fifo_empty && (fetch_left != '0) &&
                      (!wvalid_q || axi.wready);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = (xfer_len == '0) ? S_DONE : S_AW;
      S_AW:   if (axi.awready) state_nxt = S_W;
      S_W:    if (w_hs && wlast_i) state_nxt = S_B;
      S_B:    if (axi.bvalid) state_nxt = (b_err || last_burst) ? S_DONE : S_AW;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy        = state != S_IDLE;
    done        = state == S_DONE;
    axi.awvalid = state == S_AW;
    // Held at 0 outside AW so the bus reads clean while idle.
    axi.awlen   = (state == S_AW) ? 8'(beats - 9'd1) : 8'd0;
    axi.bready  = state == S_B;
    fifo_ren    = ren_i;
  end

  assign error       = error_q;
  assign axi.awaddr  = addr;
  assign axi.awsize  = 3'(SIZE);
  assign axi.awburst = 2'b01;
  assign axi.wdata   = fifo_data;
  assign axi.wstrb   = '1;
  assign axi.wvalid  = wvalid_q;
  assign axi.wlast   = wlast_i;

  // Transfer bookkeeping and beat counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr       <= '0;
      rem        <= '0;
      fetch_left <= '0;
      send_left  <= '0;
      wvalid_q   <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      if ((state == S_IDLE) && start) begin
        addr    <= dst_addr & ALIGN_MASK;
        rem     <= xfer_len;
        error_q <= 1'b0;
      end

      if (aw_hs) begin
        fetch_left <= beats;
        send_left  <= beats;
      end

      if (ren_i)     fetch_left <= fetch_left - 9'd1;
      if (w_hs)      send_left  <= send_left - 9'd1;

      // A fresh read refills the beat; otherwise an accepted beat empties it.
      if (ren_i)             wvalid_q <= 1'b1;
      else if (axi.wready)   wvalid_q <= 1'b0;

      if (b_hs) begin
        if (b_err) begin
          error_q <= 1'b1;
        end else begin
          addr <= addr + (ADDR_WIDTH'(beats) << SIZE);
          rem  <= rem - LEN_WIDTH'(beats);
        end
      end
    end
  end

endmodule

// File: tb/tb_dma_axi_write_master.sv
// Bench for dma_axi_write_master: FIFO model plus a scripted AXI slave and a bus monitor.
// Table of transfers with hand-computed AW addresses/lengths, then stall, error, zero-length and reset sequences.
module tb_dma_axi_write_master;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] dst_addr;
  logic [15:0] xfer_len;
  logic        busy, done, error, fifo_ren, fifo_empty;
  logic [31:0] fifo_data;

  dma_axi_write_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

  dma_axi_write_master #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(16), .MAX_BURST(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dst_addr(dst_addr), .xfer_len(xfer_len),
    .busy(busy), .done(done), .error(error), .fifo_ren(fifo_ren),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .axi(axi.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- FIFO model ----------------
  logic [31:0] fmem [0:255];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        fifo_hold;
  logic        fifo_flush = 1'b0;

  assign fifo_empty = (rd_ptr == wr_ptr) || fifo_hold;

  always @(posedge clk) begin
    if (fifo_flush) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_ren && (rd_ptr != wr_ptr)) begin
      fifo_data <= fmem[rd_ptr[7:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  task automatic push_words(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      fmem[wr_ptr[7:0]] = base + 32'(i);
      wr_ptr++;
    end
  endtask

  task automatic flush_fifo();
    @(posedge clk); #2;
    fifo_flush = 1'b1;
    @(posedge clk); #2;
    fifo_flush = 1'b0;
  endtask

  // ---------------- monitor + slave ----------------
  logic [31:0] aw_addr_q[$];
  logic [7:0]  aw_len_q[$];
  logic [31:0] beat_q[$];
  int          cyc = 0, wlast_cnt = 0, done_cnt = 0, done_cyc = 0, b_cyc = 0, b_count = 0;
  int          viol_aw = 0, viol_w = 0, viol_ren = 0;
  logic        last_wlast = 1'b0;
  // knobs set by the main sequence (absolute beat / burst indices)
  int          hold_at = -1, wlow_at = -1, err_at = -1, aw_wait = 0;
  // slave-private state
  int          hold_left = 0, wl_left = 0, aw_stall = 0, hold_used = -2, wl_used = -2;
  logic        b_pend = 1'b0, b_done = 1'b0;
  logic        prev_aw = 1'b0, prev_w = 1'b0, prev_wlast = 1'b0;
  logic [31:0] prev_awaddr = '0, prev_wdata = '0;
  logic [7:0]  prev_awlen = '0;

  initial begin
    axi.awready = 1'b1;
    axi.wready  = 1'b1;
    axi.bvalid  = 1'b0;
    axi.bresp   = 2'b00;
    fifo_hold   = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_aw = 1'b0;
        prev_w  = 1'b0;
      end else begin
        if (prev_aw && (!axi.awvalid || axi.awaddr != prev_awaddr || axi.awlen != prev_awlen))
          viol_aw++;
        if (prev_w && (!axi.wvalid || axi.wdata != prev_wdata || axi.wlast != prev_wlast))
          viol_w++;
        if (axi.wvalid && !axi.wready && fifo_ren) viol_ren++;
        if (axi.awvalid && axi.awready) begin
          aw_addr_q.push_back(axi.awaddr);
          aw_len_q.push_back(axi.awlen);
          aw_stall = 0;
        end
        if (axi.wvalid && axi.wready) begin
          beat_q.push_back(axi.wdata);
          last_wlast = axi.wlast;
          if (axi.wlast) begin
            wlast_cnt++;
            b_pend = 1'b1;
          end
        end
        if (axi.bvalid && axi.bready) begin
          b_count++;
          b_cyc  = cyc;
          b_done = 1'b1;
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        prev_aw     = axi.awvalid && !axi.awready;
        prev_awaddr = axi.awaddr;
        prev_awlen  = axi.awlen;
        prev_w      = axi.wvalid && !axi.wready;
        prev_wdata  = axi.wdata;
        prev_wlast  = axi.wlast;
      end

      @(posedge clk); #1;
      if (!rst_n) begin
        axi.bvalid  = 1'b0;
        axi.awready = 1'b1;
        axi.wready  = 1'b1;
        b_pend = 1'b0; b_done = 1'b0;
        hold_left = 0; wl_left = 0; aw_stall = 0;
        fifo_hold = 1'b0;
      end else begin
        if (axi.awvalid && aw_stall < aw_wait) begin
          axi.awready = 1'b0;
          aw_stall++;
        end else begin
          axi.awready = 1'b1;
        end
        if (hold_at >= 0 && hold_used != hold_at && beat_q.size() == hold_at) begin
          hold_left = 5;
          hold_used = hold_at;
        end
        fifo_hold = hold_left > 0;
        if (hold_left > 0) hold_left--;
        if (wlow_at >= 0 && wl_used != wlow_at && beat_q.size() == wlow_at && axi.wvalid) begin
          wl_left = 3;
          wl_used = wlow_at;
        end
        axi.wready = (wl_left == 0);
        if (wl_left > 0) wl_left--;
        if (b_done) begin
          axi.bvalid = 1'b0;
          b_done = 1'b0;
        end
        if (b_pend) begin
          axi.bvalid = 1'b1;
          axi.bresp  = (b_count == err_at) ? 2'b10 : 2'b00;
          b_pend = 1'b0;
        end
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] len;
    logic [1:0]  n_aw;
    logic [31:0] a0; logic [7:0] l0;
    logic [31:0] a1; logic [7:0] l1;
    logic [31:0] a2; logic [7:0] l2;
  } vec_t;

  vec_t vecs [6];

  task automatic start_xfer(input logic [31:0] a, input logic [15:0] n);
    @(posedge clk); #2;
    start = 1'b1; dst_addr = a; xfer_len = n;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input int dn0, input string name);
    int t;
    t = 0;
    while (done_cnt <= dn0 && t < 3000) begin
      @(negedge clk); #2;
      t++;
    end
    chk({name, "_timeout"}, 64'(t >= 3000), 0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int aw0, bt0, dn0, wl0, mism, n;
    logic [31:0] base;
    logic [31:0] ea [3];
    logic [7:0]  el [3];
    string nm;
    nm   = $sformatf("v%0d", idx);
    base = 32'hA000_0000 + 32'(idx) * 32'h100;
    ea[0] = v.a0; ea[1] = v.a1; ea[2] = v.a2;
    el[0] = v.l0; el[1] = v.l1; el[2] = v.l2;
    aw0 = aw_addr_q.size(); bt0 = beat_q.size(); dn0 = done_cnt; wl0 = wlast_cnt;
    push_words(int'(v.len), base);
    start_xfer(v.addr, v.len);
    chk({nm, "_awvalid_k+1"}, 64'(axi.awvalid), 1);
    wait_done(dn0, nm);
    chk({nm, "_n_aw"}, 64'(aw_addr_q.size() - aw0), 64'(v.n_aw));
    for (int i = 0; i < int'(v.n_aw) && aw0 + i < aw_addr_q.size(); i++) begin
      chk($sformatf("%s_aw%0d_addr", nm, i), 64'(aw_addr_q[aw0 + i]), 64'(ea[i]));
      chk($sformatf("%s_aw%0d_len", nm, i), 64'(aw_len_q[aw0 + i]), 64'(el[i]));
    end
    chk({nm, "_beats"}, 64'(beat_q.size() - bt0), 64'(v.len));
    n = beat_q.size() - bt0;
    if (n > int'(v.len)) n = int'(v.len);
    mism = 0;
    for (int i = 0; i < n; i++)
      if (beat_q[bt0 + i] !== base + 32'(i)) mism++;
    chk({nm, "_data_order_mismatches"}, 64'(mism), 0);
    chk({nm, "_wlast_count"}, 64'(wlast_cnt - wl0), 64'(v.n_aw));
    chk({nm, "_wlast_on_final_beat"}, 64'(last_wlast), 1);
    chk({nm, "_done_after_b"}, 64'(done_cyc - b_cyc), 1);
    chk({nm, "_error"}, 64'(error), 0);
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk({nm, "_busy_after"}, 64'(busy), 0);
    chk({nm, "_done_pulses"}, 64'(done_cnt - dn0), 1);
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk({nm, "_ctl"}, {56'h0, axi.awvalid, axi.wvalid, axi.bready, fifo_ren,
                       busy, done, axi.wlast, error}, 0);
    chk({nm, "_awaddr"}, 64'(axi.awaddr), 0);
    chk({nm, "_awlen"}, 64'(axi.awlen), 0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int aw0, bt0, dn0, t;
    vec_t sv;

    vecs[0] = '{32'h0000_1000, 16'd4,  2'd1, 32'h0000_1000, 8'd3,  32'h0,         8'd0,  32'h0,  8'd0};
    vecs[1] = '{32'h0000_0000, 16'd40, 2'd3, 32'h0000_0000, 8'd15, 32'h0000_0040, 8'd15, 32'h80, 8'd7};
    vecs[2] = '{32'h0000_0FF8, 16'd4,  2'd2, 32'h0000_0FF8, 8'd1,  32'h0000_1000, 8'd1,  32'h0,  8'd0};
    vecs[3] = '{32'h0000_0003, 16'd5,  2'd1, 32'h0000_0000, 8'd4,  32'h0,         8'd0,  32'h0,  8'd0};
    vecs[4] = '{32'h0000_0FC0, 16'd20, 2'd2, 32'h0000_0FC0, 8'd15, 32'h0000_1000, 8'd3,  32'h0,  8'd0};
    vecs[5] = '{32'hFFFF_FFF8, 16'd3,  2'd2, 32'hFFFF_FFF8, 8'd1,  32'h0000_0000, 8'd0,  32'h0,  8'd0};

    rst_n = 1'b0; start = 1'b0; dst_addr = '0; xfer_len = '0;
    repeat (3) @(posedge clk);
    #2;
    chk_outputs_zero("in_reset");
    rst_n = 1'b1;
    @(posedge clk); #2;
    chk_outputs_zero("after_reset");
    chk("awsize", 64'(axi.awsize), 2);
    chk("awburst", 64'(axi.awburst), 1);
    chk("wstrb", 64'(axi.wstrb), 64'hF);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Stalls: FIFO empty 5 cycles after beat 3, wready low 3 cycles at beat 8, AW held off 2 cycles.
    sv = '{32'h0000_2000, 16'd12, 2'd1, 32'h0000_2000, 8'd11, 32'h0, 8'd0, 32'h0, 8'd0};
    hold_at = beat_q.size() + 3;
    wlow_at = beat_q.size() + 8;
    aw_wait = 2;
    run_vec(sv, 6);
    aw_wait = 0;
    chk("stall_hold_fired", 64'(hold_used == hold_at), 1);
    chk("stall_wlow_fired", 64'(wl_used == wlow_at), 1);
    chk("stall_ren_while_blocked", 64'(viol_ren), 0);
    chk("stall_w_unstable", 64'(viol_w), 0);
    chk("stall_aw_unstable", 64'(viol_aw), 0);

    // Error on the first of three bursts.
    aw0 = aw_addr_q.size(); bt0 = beat_q.size(); dn0 = done_cnt;
    push_words(40, 32'hE000_0000);
    err_at = b_count;
    start_xfer(32'h0000_4000, 16'd40);
    wait_done(dn0, "err");
    chk("err_error_set", 64'(error), 1);
    chk("err_beats", 64'(beat_q.size() - bt0), 16);
    repeat (5) @(posedge clk);
    #2;
    chk("err_n_aw", 64'(aw_addr_q.size() - aw0), 1);
    chk("err_sticky", 64'(error), 1);
    chk("err_idle", 64'(busy), 0);
    chk("err_done_pulses", 64'(done_cnt - dn0), 1);
    err_at = -1;
    flush_fifo();

    // Zero length; also the start that clears the sticky error.
    aw0 = aw_addr_q.size(); dn0 = done_cnt;
    start_xfer(32'h0000_5000, 16'd0);
    chk("zero_done_high", 64'(done), 1);
    chk("zero_error_cleared", 64'(error), 0);
    chk("zero_no_awvalid", 64'(axi.awvalid), 0);
    @(posedge clk); #2;
    chk("zero_done_fell_2cyc", 64'(done), 0);
    chk("zero_busy_fell", 64'(busy), 0);
    repeat (3) @(posedge clk);
    #2;
    chk("zero_no_aw", 64'(aw_addr_q.size() - aw0), 0);
    chk("zero_done_pulses", 64'(done_cnt - dn0), 1);

    // Reset in the middle of the data phase.
    bt0 = beat_q.size();
    push_words(16, 32'hC000_0000);
    start_xfer(32'h0000_3000, 16'd16);
    t = 0;
    while (beat_q.size() < bt0 + 3 && t < 200) begin
      @(negedge clk); #2;
      t++;
    end
    chk("rst_mid_w_timeout", 64'(t >= 200), 0);
    chk("rst_mid_w_was_busy", 64'(busy), 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("rst_mid_w");
    flush_fifo();
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    chk_outputs_zero("rst_released");
    run_vec(vecs[0], 7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
